// File: rtl/inv_mix_col_iter_if.sv
// Handshake bundle for the iterative InvMixColumns engine.
//   in_valid / in_ready / state_in    : upstream state transfer
//   out_valid / out_ready / state_out : downstream result transfer
// master modport: producer/consumer side; slave modport: the engine.
interface inv_mix_col_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out
  );
endinterface

// File: rtl/inv_mix_col_iter.sv
// Iterative AES InvMixColumns engine. Accepts a 128-bit column-major state,
// transforms COLS_PER_CYCLE columns per RUN cycle in place, then holds the
// result until the consumer takes it.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : inv_mix_col_iter_if.slave (in_valid/in_ready/state_in,
//          out_valid/out_ready/state_out)
module inv_mix_col_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                rst,
  inv_mix_col_iter_if.slave   bus
);

  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned COL_W    = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("inv_mix_col_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Multiply by 02 in GF(2^8), poly 0x11B.
  function automatic logic [7:0] f_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Inverse mix of one column {r0,r1,r2,r3} using the 0e/0b/0d/09 circulant.
  function automatic logic [31:0] f_inv_col(input logic [31:0] col);
    logic [7:0] v   [4];
    logic [7:0] m09 [4];
    logic [7:0] m0b [4];
    logic [7:0] m0d [4];
    logic [7:0] m0e [4];
    logic [7:0] x2, x4, x8;
    for (int r = 0; r < 4; r++) begin
      v[r]   = col[31-8*r -: 8];
      x2     = f_xtime(v[r]);
      x4     = f_xtime(x2);
      x8     = f_xtime(x4);
      m09[r] = x8 ^ v[r];
      m0b[r] = x8 ^ x2 ^ v[r];
      m0d[r] = x8 ^ x4 ^ v[r];
      m0e[r] = x8 ^ x4 ^ x2;
    end
    return {m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3],
            m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3],
            m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3],
            m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3]};
  endfunction

  logic [1:0]       r_state;
  logic [127:0]     r_st;
  logic [COL_W-1:0] r_col;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [1:0]       w_state_nxt;
  logic [127:0]     w_st_nxt;
  logic [COL_W-1:0] w_col_nxt;
  logic             w_in_ready_nxt;
  logic             w_out_valid_nxt;

  logic [127:0]     w_run_st;
  logic [COL_W:0]   w_col_sum;

  // Sum carries into bit COL_W exactly when the last column group is written.
  assign w_col_sum = (COL_W+1)'(r_col) + (COL_W+1)'(COLS_PER_CYCLE);

  // Replace the columns that fall in the current window [r_col, r_col+COLS).
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    logic [COL_W-1:0] w_off;
    assign w_off = COL_W'(c) - r_col;
    assign w_run_st[127-32*c -: 32] = (32'(w_off) < COLS_PER_CYCLE)
                                      ? f_inv_col(r_st[127-32*c -: 32])
                                      : r_st[127-32*c -: 32];
  end

  // Next-state and registered-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_st_nxt        = r_st;
    w_col_nxt       = r_col;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_st_nxt       = bus.state_in;
          w_col_nxt      = '0;
          w_state_nxt    = S_RUN;
          w_in_ready_nxt = 1'b0;
        end
      end
      S_RUN: begin
        w_st_nxt  = w_run_st;
        w_col_nxt = w_col_sum[COL_W-1:0];
        if (w_col_sum[COL_W]) begin
          w_state_nxt     = S_DONE;
          w_out_valid_nxt = 1'b1;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt     = S_IDLE;
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_in_ready_nxt  = 1'b1;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_st        <= '0;
      r_col       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_st        <= w_st_nxt;
      r_col       <= w_col_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.state_out = r_st;

endmodule

// File: tb/tb_inv_mix_col_iter.sv
// Self-checking bench for inv_mix_col_iter: directed FIPS-197 vectors,
// latency for 1/2/4 columns per cycle, back-pressure, mid-run reset,
// back-to-back streaming and randomized traffic against a GF(2^8) model.
module tb_inv_mix_col_iter;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  inv_mix_col_iter_if u_if1();
  inv_mix_col_iter_if u_if2();
  inv_mix_col_iter_if u_if4();

  inv_mix_col_iter #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));
  inv_mix_col_iter #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(u_if2));
  inv_mix_col_iter #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(u_if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic shift-and-add GF(2^8) multiply, poly 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    logic       hi;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      hi = x[7];
      x  = {x[6:0], 1'b0};
      if (hi) x = x ^ 8'h1B;
      y  = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Column-wise circulant matrix product; row r uses base rotated right by r.
  function automatic logic [127:0] mix_ref(input logic [127:0] s,
                                           input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0]   base [4];
    logic [127:0] o;
    logic [7:0]   acc;
    base = '{b0, b1, b2, b3};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(s[127-8*(4*c+k) -: 8], base[(k-r) & 3]);
        o[127-8*(4*c+r) -: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] inv_ref(input logic [127:0] s);
    return mix_ref(s, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic logic [127:0] fwd_ref(input logic [127:0] s);
    return mix_ref(s, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction on the 1-column engine; optional out_ready noise while
  // running and a random stall once the result is up.
  task automatic run_one(input logic [127:0] s, input bit noise,
                         output logic [127:0] res, output int lat);
    int guard;
    int stall;
    guard = 0;
    while (!u_if1.in_ready && guard < 20) begin tick(); guard++; end
    check("in_ready_wait", 128'(u_if1.in_ready), 128'(1));
    u_if1.in_valid = 1'b1;
    u_if1.state_in = s;
    tick();
    u_if1.in_valid = 1'b0;
    u_if1.state_in = rnd128();
    lat = 0;
    while (!u_if1.out_valid && lat < 20) begin
      if (noise) u_if1.out_ready = 1'($urandom);
      tick();
      lat++;
    end
    u_if1.out_ready = 1'b0;
    res = u_if1.state_out;
    if (noise) begin
      stall = int'($urandom_range(0, 3));
      if (stall > 0) begin
        repeat (stall) tick();
        check("stall_hold", u_if1.state_out, res);
      end
    end
    u_if1.out_ready = 1'b1;
    tick();
    u_if1.out_ready = 1'b0;
  endtask

  localparam logic [127:0] T1_IN  = 128'h8e4da1bc_00000000_00000000_00000000;
  localparam logic [127:0] T1_OUT = 128'hdb135345_00000000_00000000_00000000;
  localparam logic [127:0] T2_IN  = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;
  localparam logic [127:0] T2_OUT = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] T4_IN  = 128'h4d7ebdf8_00000000_00000000_00000000;
  localparam logic [127:0] T4_OUT = 128'h2d26314c_00000000_00000000_00000000;

  initial begin
    logic [127:0] res;
    logic [127:0] s;
    logic [127:0] res2, res4, res1;
    logic [127:0] q_in [3];
    logic [127:0] q_out [$];
    int lat, lat1, lat2, lat4, guard, sent, cyc;
    bit acc;

    n_vec = 0;
    n_err = 0;
    u_if1.in_valid = 1'b0; u_if1.state_in = '0; u_if1.out_ready = 1'b0;
    u_if2.in_valid = 1'b0; u_if2.state_in = '0; u_if2.out_ready = 1'b0;
    u_if4.in_valid = 1'b0; u_if4.state_in = '0; u_if4.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_out_valid", 128'(u_if1.out_valid), 128'(0));
    check("rst_state_out", u_if1.state_out, '0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", 128'(u_if1.in_ready), 128'(1));

    // Single-column FIPS vector.
    run_one(T1_IN, 1'b0, res, lat);
    check("t1_result", res, T1_OUT);
    check("t1_model", inv_ref(T1_IN), T1_OUT);
    check("t1_latency", 128'(lat), 128'(4));

    // Full state on all three widths at once.
    u_if1.in_valid = 1'b1; u_if1.state_in = T2_IN;
    u_if2.in_valid = 1'b1; u_if2.state_in = T2_IN;
    u_if4.in_valid = 1'b1; u_if4.state_in = T2_IN;
    tick();
    u_if1.in_valid = 1'b0; u_if2.in_valid = 1'b0; u_if4.in_valid = 1'b0;
    lat1 = 0; lat2 = 0; lat4 = 0;
    res1 = '0; res2 = '0; res4 = '0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (u_if1.out_valid && lat1 == 0) begin lat1 = c; res1 = u_if1.state_out; end
      if (u_if2.out_valid && lat2 == 0) begin lat2 = c; res2 = u_if2.state_out; end
      if (u_if4.out_valid && lat4 == 0) begin lat4 = c; res4 = u_if4.state_out; end
    end
    check("t2_lat_c1", 128'(lat1), 128'(4));
    check("t2_lat_c2", 128'(lat2), 128'(2));
    check("t2_lat_c4", 128'(lat4), 128'(1));
    check("t2_res_c1", res1, T2_OUT);
    check("t2_res_c2", res2, T2_OUT);
    check("t2_res_c4", res4, T2_OUT);
    check("t2_model", inv_ref(T2_IN), T2_OUT);
    u_if1.out_ready = 1'b1; u_if2.out_ready = 1'b1; u_if4.out_ready = 1'b1;
    tick();
    u_if1.out_ready = 1'b0; u_if2.out_ready = 1'b0; u_if4.out_ready = 1'b0;
    check("t2_c2_idle", 128'(u_if2.in_ready), 128'(1));
    check("t2_c4_idle", 128'(u_if4.in_ready), 128'(1));

    // Back-pressure: DONE held for 10 cycles with stray in_valid pulses.
    u_if1.in_valid = 1'b1; u_if1.state_in = T2_IN;
    tick();
    u_if1.in_valid = 1'b0;
    guard = 0;
    while (!u_if1.out_valid && guard < 20) begin tick(); guard++; end
    for (int i = 0; i < 10; i++) begin
      u_if1.in_valid = 1'(i & 1);
      u_if1.state_in = rnd128();
      tick();
      check("bp_out_valid", 128'(u_if1.out_valid), 128'(1));
      check("bp_state_out", u_if1.state_out, T2_OUT);
      check("bp_in_ready", 128'(u_if1.in_ready), 128'(0));
    end
    u_if1.in_valid = 1'b0;
    u_if1.out_ready = 1'b1;
    tick();
    u_if1.out_ready = 1'b0;
    check("bp_release_ready", 128'(u_if1.in_ready), 128'(1));
    check("bp_release_valid", 128'(u_if1.out_valid), 128'(0));

    // Reset in the middle of RUN.
    u_if1.in_valid = 1'b1; u_if1.state_in = rnd128() | 128'h1;
    tick();
    u_if1.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(u_if1.out_valid), 128'(0));
    check("mid_rst_state_out", u_if1.state_out, '0);
    check("mid_rst_in_ready", 128'(u_if1.in_ready), 128'(1));
    tick();
    rst = 1'b0;
    tick();
    run_one(T4_IN, 1'b0, res, lat);
    check("post_rst_result", res, T4_OUT);
    check("post_rst_model", inv_ref(T4_IN), T4_OUT);

    // Back-to-back stream of three states.
    for (int i = 0; i < 3; i++) q_in[i] = rnd128() ^ 128'(i + 1);
    q_out.delete();
    sent = 0; cyc = 0;
    u_if1.out_ready = 1'b1;
    u_if1.in_valid  = 1'b1;
    u_if1.state_in  = q_in[0];
    while (q_out.size() < 3 && cyc < 60) begin
      acc = u_if1.in_valid && u_if1.in_ready;
      if (u_if1.out_valid) q_out.push_back(u_if1.state_out);
      tick();
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 3) u_if1.state_in = q_in[sent];
        else          u_if1.in_valid = 1'b0;
      end
    end
    repeat (8) begin
      if (u_if1.out_valid) q_out.push_back(u_if1.state_out);
      tick();
    end
    u_if1.out_ready = 1'b0;
    u_if1.in_valid  = 1'b0;
    check("b2b_count", 128'(q_out.size()), 128'(3));
    for (int i = 0; i < 3; i++)
      check("b2b_result", (i < q_out.size()) ? q_out[i] : '0, inv_ref(q_in[i]));

    // Randomized traffic with out_ready noise and stalls.
    for (int i = 0; i < 1000; i++) begin
      s = rnd128();
      run_one(s, 1'b1, res, lat);
      check("rand_result", res, inv_ref(s));
      check("rand_roundtrip", fwd_ref(res), s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
